stage_wb_queue: RTL and testbench
=================================

STAGE_WB_QUEUE -- requirements
Module: stage_wb_queue

Interface
REQ-001 Parameter DEPTH, default 2: writeback queue entries, power of two, 2..8.
REQ-002 Parameter DATA_W, default 32: result/CSR data width.
REQ-003 Parameter CSRN_W, default 14: CSR number width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 ms_to_ws_valid  in  1  entry offered by MEM stage.
REQ-007 ws_allow_in  out  1  queue accepts an entry this cycle.
REQ-008 in_pc  in  32  entry PC.
REQ-009 in_gr_we / in_dest / in_result  in  1/5/DATA_W  GPR write request.
REQ-010 in_csr_re / in_csr_we / in_csr_num / in_csr_wmask / in_csr_wvalue  in  1/1/CSRN_W/DATA_W/DATA_W  CSR access.
REQ-011 in_ertn  in  1  entry is ERTN.
REQ-012 in_exc  in  6  exception flags {INT,ADEF,INE,SYS,BRK,ALE}, bit5=INT.
REQ-013 in_vaddr  in  32  faulting address.
REQ-014 csr_stall  in  1  CSR file busy; head may not retire.
REQ-015 csr_num / csr_re / csr_we / csr_wmask / csr_wvalue  out  CSRN_W/1/1/DATA_W/DATA_W  CSR port, head entry.
REQ-016 csr_rvalue  in  DATA_W  CSR read data, same cycle.
REQ-017 rf_we / rf_waddr / rf_wdata  out  1/5/DATA_W  GPR write port.
REQ-018 wb_ex / wb_ecode / wb_esubcode / wb_pc / wb_vaddr  out  1/6/9/32/32  exception commit.
REQ-019 ertn_flush  out  1  ERTN commit.
REQ-020 ws_flush  out  1  pipeline flush pulse to earlier stages.
REQ-021 fwd_valid / fwd_dest / fwd_data / fwd_csr_pending  out  1/5/DATA_W/1  forwarding from newest valid GPR-writing entry; fwd_csr_pending high if any valid entry has csr_we or ertn.
REQ-022 retire_cnt  out  64  retired-instruction counter.

Function
REQ-023 Queue SHALL be circular FIFO of DEPTH entries with head/tail pointers and occupancy count 0..DEPTH.
REQ-024 ws_allow_in SHALL equal (count<DEPTH) || retire, and SHALL be 0 while ws_flush is high.
REQ-025 Push occurs when ms_to_ws_valid && ws_allow_in; entry written at tail, tail wraps DEPTH-1 -> 0.
REQ-026 Retire SHALL occur when count>0 && !csr_stall; head advances with same wrap rule; simultaneous push+retire leaves count unchanged.
REQ-027 All commit outputs SHALL be combinational from head entry, qualified by retire; rf_we, csr_we, wb_ex, ertn_flush all 0 when no retire.
REQ-028 rf_wdata SHALL be csr_rvalue when head csr_re, else head result; csr_re output equals head csr_re.
REQ-029 wb_ex = retire && |head exc; rf_we and csr_we SHALL be forced 0 on exception retire.
REQ-030 wb_ecode priority INT 0x0 > ADEF 0x8 > INE 0xD > SYS 0xB > BRK 0xC > ALE 0x9; wb_esubcode always 0.
REQ-031 ertn_flush = retire && head ertn && !wb_ex.
REQ-032 ws_flush SHALL pulse high exactly one cycle, registered, the cycle after wb_ex or ertn_flush retire.
REQ-033 On wb_ex or ertn_flush retire all other queue entries SHALL be discarded at the clock edge (count->0, head=tail), any same-cycle push dropped.
REQ-034 Entries accepted during ws_flush high: none (per REQ-024).
REQ-035 retire_cnt SHALL increment by 1 per retire without exception, wrapping 2^64-1 -> 0.
REQ-036 Retire latency: entry pushed at edge N is visible at head and may retire in cycle N+1 if queue was empty.
REQ-037 fwd outputs SHALL cover valid entries only; fwd_valid=0 when count=0.

Reset
REQ-038 resetn low SHALL immediately clear count, head, tail, ws_flush, retire_cnt; all commit outputs 0, ws_allow_in 1 after release.
REQ-039 Reset asserted mid-operation SHALL discard queued entries without any commit.

Verification
REQ-040 Empty queue, push pc=0x1c000000 gr_we dest=4 result=0x55 -> next cycle rf_we=1, rf_waddr=4, rf_wdata=0x55, retire_cnt=1.
REQ-041 DEPTH=2, csr_stall=1, three pushes -> count=2, ws_allow_in=0, third held; drop csr_stall -> one retire per cycle in order.
REQ-042 Head in_exc=6'b010001 (ADEF+ALE), second entry queued -> wb_ecode=0x8, rf_we=0, ws_flush one cycle, second entry never commits, count=0.
REQ-043 Head csr_re=1, csr_num=0x5, csr_rvalue=0xABCD -> rf_wdata=0xABCD.
REQ-044 Head ertn with a push same cycle -> ertn_flush=1, push dropped, ws_allow_in=0 during ws_flush.
REQ-045 resetn pulsed low with 2 entries queued -> no rf_we, count=0, retire_cnt=0.

Source files
------------

// File: rtl/stage_wb_queue.sv
// Writeback-stage queue: buffers MEM-stage results in a small circular FIFO and
// commits the head entry to the GPR file, the CSR port and the exception/ERTN logic.
module stage_wb_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CSRN_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_to_ws_valid,
  output logic              ws_allow_in,
  input  logic [31:0]       in_pc,
  input  logic              in_gr_we,
  input  logic [4:0]        in_dest,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_csr_re,
  input  logic              in_csr_we,
  input  logic [CSRN_W-1:0] in_csr_num,
  input  logic [DATA_W-1:0] in_csr_wmask,
  input  logic [DATA_W-1:0] in_csr_wvalue,
  input  logic              in_ertn,
  input  logic [5:0]        in_exc,
  input  logic [31:0]       in_vaddr,
  input  logic              csr_stall,
  output logic [CSRN_W-1:0] csr_num,
  output logic              csr_re,
  output logic              csr_we,
  output logic [DATA_W-1:0] csr_wmask,
  output logic [DATA_W-1:0] csr_wvalue,
  input  logic [DATA_W-1:0] csr_rvalue,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_ex,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_vaddr,
  output logic              ertn_flush,
  output logic              ws_flush,
  output logic              fwd_valid,
  output logic [4:0]        fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_csr_pending,
  output logic [63:0]       retire_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]       pc;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic              csr_re;
    logic              csr_we;
    logic [CSRN_W-1:0] csr_num;
    logic [DATA_W-1:0] csr_wmask;
    logic [DATA_W-1:0] csr_wvalue;
    logic              ertn;
    logic [5:0]        exc;
    logic [31:0]       vaddr;
  } entry_t;

  entry_t            entries_q [DEPTH];
  entry_t            in_entry, head;
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d, fwd_idx;
  logic [CntW-1:0]   count_q, count_d;
  logic [63:0]       retire_cnt_q, retire_cnt_d;
  logic              ws_flush_q, ws_flush_d;
  logic              head_valid, head_exc, retire, push, wr_en;
  logic [5:0]        ecode;

  assign in_entry = '{pc: in_pc, gr_we: in_gr_we, dest: in_dest, result: in_result,
                      csr_re: in_csr_re, csr_we: in_csr_we, csr_num: in_csr_num,
                      csr_wmask: in_csr_wmask, csr_wvalue: in_csr_wvalue, ertn: in_ertn,
                      exc: in_exc, vaddr: in_vaddr};

  assign head       = entries_q[head_q];
  assign head_valid = (count_q != '0);
  assign head_exc   = |head.exc;
  assign retire     = head_valid && !csr_stall;

  assign ws_allow_in = !ws_flush_q && ((count_q < CntW'(DEPTH)) || retire);
  assign push        = ms_to_ws_valid && ws_allow_in;

  assign wb_ex      = retire && head_exc;
  assign ertn_flush = retire && head.ertn && !head_exc;
  assign ws_flush_d = wb_ex || ertn_flush;
  // A flushing retire kills everything younger, including a same-cycle push.
  assign wr_en      = push && !ws_flush_d;

  always_comb begin
    if      (head.exc[5]) ecode = 6'h00;
    else if (head.exc[4]) ecode = 6'h08;
    else if (head.exc[3]) ecode = 6'h0D;
    else if (head.exc[2]) ecode = 6'h0B;
    else if (head.exc[1]) ecode = 6'h0C;
    else                  ecode = 6'h09;
  end

  assign wb_ecode    = wb_ex ? ecode : 6'h00;
  assign wb_esubcode = 9'h000;
  assign wb_pc       = retire ? head.pc : 32'h0;
  assign wb_vaddr    = retire ? head.vaddr : 32'h0;

  assign rf_we    = retire && head.gr_we && !head_exc;
  assign rf_waddr = retire ? head.dest : 5'h00;
  assign rf_wdata = !retire ? '0 : (head.csr_re ? csr_rvalue : head.result);

  assign csr_num    = head_valid ? head.csr_num : '0;
  assign csr_re     = head_valid && head.csr_re;
  assign csr_we     = retire && head.csr_we && !head_exc;
  assign csr_wmask  = retire ? head.csr_wmask : '0;
  assign csr_wvalue = retire ? head.csr_wvalue : '0;

  assign ws_flush   = ws_flush_q;
  assign retire_cnt = retire_cnt_q;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    retire_cnt_d = retire_cnt_q + ((retire && !head_exc) ? 64'd1 : 64'd0);
    if (ws_flush_d) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (retire) head_d = head_q + PtrW'(1);
      if (push)   tail_d = tail_q + PtrW'(1);
      if (push && !retire)      count_d = count_q + CntW'(1);
      else if (!push && retire) count_d = count_q - CntW'(1);
    end
  end

  // Walk oldest to newest so the youngest GPR writer wins.
  always_comb begin
    fwd_valid       = 1'b0;
    fwd_dest        = 5'h00;
    fwd_data        = '0;
    fwd_csr_pending = 1'b0;
    fwd_idx         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if (entries_q[fwd_idx].gr_we) begin
          fwd_valid = 1'b1;
          fwd_dest  = entries_q[fwd_idx].dest;
          fwd_data  = entries_q[fwd_idx].result;
        end
        if (entries_q[fwd_idx].csr_we || entries_q[fwd_idx].ertn) fwd_csr_pending = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      retire_cnt_q <= '0;
      ws_flush_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      retire_cnt_q <= retire_cnt_d;
      ws_flush_q   <= ws_flush_d;
      if (wr_en) entries_q[tail_q] <= in_entry;
    end
  end

endmodule

// File: tb/tb_stage_wb_queue.sv
// Bench for stage_wb_queue: directed scenarios plus a randomized run, all checked
// against a queue-based model of the writeback stage kept in this file.
module tb_stage_wb_queue;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic [5:0]  exc;
    logic [31:0] vaddr;
  } ent_t;

  logic clk, resetn, in_v, stall;
  ent_t in_e;
  logic [31:0] rvalue;

  logic        ws_allow_in, csr_re, csr_we, rf_we, wb_ex, ertn_flush, ws_flush;
  logic        fwd_valid, fwd_csr_pending;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, rf_wdata, wb_pc, wb_vaddr, fwd_data;
  logic [4:0]  rf_waddr, fwd_dest;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [63:0] retire_cnt;

  stage_wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .CSRN_W(14)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(in_v), .ws_allow_in(ws_allow_in),
    .in_pc(in_e.pc), .in_gr_we(in_e.gr_we), .in_dest(in_e.dest), .in_result(in_e.result),
    .in_csr_re(in_e.csr_re), .in_csr_we(in_e.csr_we), .in_csr_num(in_e.csr_num),
    .in_csr_wmask(in_e.csr_wmask), .in_csr_wvalue(in_e.csr_wvalue), .in_ertn(in_e.ertn),
    .in_exc(in_e.exc), .in_vaddr(in_e.vaddr), .csr_stall(stall),
    .csr_num(csr_num), .csr_re(csr_re), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .csr_rvalue(rvalue), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .ws_flush(ws_flush),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_csr_pending(fwd_csr_pending), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;

  // Reference model state
  ent_t        mq[$];
  bit          flush_pend;
  logic [63:0] rcnt;
  logic [5:0]  ecode_tab [6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

  bit          e_retire, e_exc, e_allow, e_rf_we, e_csr_we, e_csr_re, e_wb_ex, e_ertn;
  bit          e_fwd_valid, e_pend;
  logic [4:0]  e_waddr, e_fwd_dest;
  logic [31:0] e_wdata, e_fwd_data, e_pc, e_vaddr;
  logic [5:0]  e_ecode;

  task automatic model_eval();
    ent_t h;
    h          = (mq.size() > 0) ? mq[0] : '0;
    e_retire   = (mq.size() > 0) && !stall;
    e_exc      = (h.exc != 6'd0);
    e_wb_ex    = e_retire && e_exc;
    e_ertn     = e_retire && h.ertn && !e_exc;
    e_allow    = !flush_pend && ((mq.size() < DEPTH) || e_retire);
    e_rf_we    = e_retire && h.gr_we && !e_exc;
    e_csr_we   = e_retire && h.csr_we && !e_exc;
    e_csr_re   = (mq.size() > 0) && h.csr_re;
    e_waddr    = h.dest;
    e_wdata    = h.csr_re ? rvalue : h.result;
    e_pc       = h.pc;
    e_vaddr    = h.vaddr;
    e_ecode    = 6'h00;
    for (int k = 0; k < 6; k++) begin
      if (h.exc[5-k]) begin
        e_ecode = ecode_tab[k];
        break;
      end
    end
    e_fwd_valid = 1'b0;
    e_fwd_dest  = 5'h00;
    e_fwd_data  = 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].gr_we) begin
        e_fwd_valid = 1'b1;
        e_fwd_dest  = mq[i].dest;
        e_fwd_data  = mq[i].result;
        break;
      end
    end
    e_pend = 1'b0;
    foreach (mq[i]) if (mq[i].csr_we || mq[i].ertn) e_pend = 1'b1;
  endtask

  task automatic model_update();
    bit nflush;
    nflush = e_wb_ex || e_ertn;
    if (e_retire) begin
      if (!e_exc) rcnt = rcnt + 64'd1;
      void'(mq.pop_front());
    end
    if (nflush) mq.delete();
    else if (in_v && e_allow) mq.push_back(in_e);
    flush_pend = nflush;
  endtask

  task automatic model_reset();
    mq.delete();
    flush_pend = 1'b0;
    rcnt       = 64'd0;
  endtask

  // Inputs change just after a rising edge; outputs are sampled 2ns later.
  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic gw, input logic [4:0] d,
                              input logic [31:0] r);
    ent_t e;
    e        = '0;
    e.pc     = pc;
    e.gr_we  = gw;
    e.dest   = d;
    e.result = r;
    return e;
  endfunction

  task automatic test_reset();
    in_v = 0; stall = 0; rvalue = '0; in_e = '0; resetn = 0;
    model_reset();
    #3;
    compared++; if (ws_allow_in !== 1'b1) begin failed++; $display("FAIL rst_allow got %0b exp 1", ws_allow_in); end
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL rst_rf_we got %0b exp 0", rf_we); end
    compared++; if (wb_ex !== 1'b0) begin failed++; $display("FAIL rst_wb_ex got %0b exp 0", wb_ex); end
    compared++; if (ertn_flush !== 1'b0) begin failed++; $display("FAIL rst_ertn got %0b exp 0", ertn_flush); end
    compared++; if (ws_flush !== 1'b0) begin failed++; $display("FAIL rst_ws_flush got %0b exp 0", ws_flush); end
    compared++; if (csr_we !== 1'b0) begin failed++; $display("FAIL rst_csr_we got %0b exp 0", csr_we); end
    compared++; if (fwd_valid !== 1'b0) begin failed++; $display("FAIL rst_fwd_valid got %0b exp 0", fwd_valid); end
    compared++; if (retire_cnt !== 64'd0) begin failed++; $display("FAIL rst_retire_cnt got %0h exp 0", retire_cnt); end
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    in_e = mk(32'h1c000000, 1'b1, 5'd4, 32'h55); in_v = 1;
    settle();
    compared++; if (ws_allow_in !== e_allow) begin failed++; $display("FAIL basic_allow got %0b exp %0b", ws_allow_in, e_allow); end
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL basic_empty_rf_we got %0b exp 0", rf_we); end
    tick();
    in_v = 0;
    settle();
    compared++; if (rf_we !== 1'b1) begin failed++; $display("FAIL basic_rf_we got %0b exp 1", rf_we); end
    compared++; if (rf_waddr !== 5'd4) begin failed++; $display("FAIL basic_waddr got %0d exp 4", rf_waddr); end
    compared++; if (rf_wdata !== 32'h55) begin failed++; $display("FAIL basic_wdata got %0h exp 55", rf_wdata); end
    compared++; if (wb_pc !== 32'h1c000000) begin failed++; $display("FAIL basic_pc got %0h exp 1c000000", wb_pc); end
    tick();
    settle();
    compared++; if (retire_cnt !== 64'd1) begin failed++; $display("FAIL basic_retire_cnt got %0h exp 1", retire_cnt); end
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL basic_drained got %0b exp 0", rf_we); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 1; i <= 3; i++) begin
      in_e = mk(32'h1c000100 + 32'(i * 4), 1'b1, 5'(i), 32'h11 * 32'(i)); in_v = 1;
      settle();
      if (i == 3) begin
        compared++; if (ws_allow_in !== 1'b0) begin failed++; $display("FAIL stall_full_allow got %0b exp 0", ws_allow_in); end
      end
      tick();
    end
    stall = 0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      compared++; if (rf_we !== 1'b1) begin failed++; $display("FAIL stall_rf_we[%0d] got %0b exp 1", i, rf_we); end
      compared++; if (rf_waddr !== 5'(i)) begin failed++; $display("FAIL stall_order[%0d] got %0d exp %0d", i, rf_waddr, i); end
      tick();
      in_v = 0;
    end
    settle();
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL stall_drained got %0b exp 0", rf_we); end
    compared++; if (retire_cnt !== 64'd4) begin failed++; $display("FAIL stall_retire_cnt got %0h exp 4", retire_cnt); end
    tick();
  endtask

  task automatic test_exception();
    stall = 1;
    in_e = mk(32'h1c000200, 1'b1, 5'd7, 32'h77); in_e.exc = 6'b010001; in_e.vaddr = 32'hdead0003;
    in_v = 1; tick();
    in_e = mk(32'h1c000204, 1'b1, 5'd8, 32'h88); tick();
    in_v = 0; stall = 0;
    settle();
    compared++; if (wb_ex !== 1'b1) begin failed++; $display("FAIL exc_wb_ex got %0b exp 1", wb_ex); end
    compared++; if (wb_ecode !== 6'h08) begin failed++; $display("FAIL exc_ecode got %0h exp 8", wb_ecode); end
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL exc_rf_we got %0b exp 0", rf_we); end
    compared++; if (wb_vaddr !== 32'hdead0003) begin failed++; $display("FAIL exc_vaddr got %0h exp dead0003", wb_vaddr); end
    tick();
    settle();
    compared++; if (ws_flush !== 1'b1) begin failed++; $display("FAIL exc_flush got %0b exp 1", ws_flush); end
    compared++; if (ws_allow_in !== 1'b0) begin failed++; $display("FAIL exc_allow got %0b exp 0", ws_allow_in); end
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL exc_second_commit got %0b exp 0", rf_we); end
    compared++; if (fwd_valid !== 1'b0) begin failed++; $display("FAIL exc_fwd_valid got %0b exp 0", fwd_valid); end
    tick();
    settle();
    compared++; if (ws_flush !== 1'b0) begin failed++; $display("FAIL exc_flush_len got %0b exp 0", ws_flush); end
    compared++; if (retire_cnt !== rcnt) begin failed++; $display("FAIL exc_retire_cnt got %0h exp %0h", retire_cnt, rcnt); end
    tick();
  endtask

  task automatic test_csr_read();
    in_e = mk(32'h1c000300, 1'b1, 5'd9, 32'h1234); in_e.csr_re = 1; in_e.csr_num = 14'h5;
    in_v = 1; tick();
    in_v = 0; rvalue = 32'hABCD;
    settle();
    compared++; if (csr_re !== 1'b1) begin failed++; $display("FAIL csr_re got %0b exp 1", csr_re); end
    compared++; if (csr_num !== 14'h5) begin failed++; $display("FAIL csr_num got %0h exp 5", csr_num); end
    compared++; if (rf_wdata !== 32'hABCD) begin failed++; $display("FAIL csr_wdata got %0h exp abcd", rf_wdata); end
    tick();
  endtask

  task automatic test_ertn();
    stall = 1;
    in_e = mk(32'h1c000400, 1'b0, 5'd0, 32'h0); in_e.ertn = 1; in_v = 1; tick();
    stall = 0;
    in_e = mk(32'h1c000404, 1'b1, 5'd10, 32'hA0);
    settle();
    compared++; if (ertn_flush !== 1'b1) begin failed++; $display("FAIL ertn_flush got %0b exp 1", ertn_flush); end
    compared++; if (fwd_csr_pending !== 1'b1) begin failed++; $display("FAIL ertn_pending got %0b exp 1", fwd_csr_pending); end
    tick();
    settle();
    compared++; if (ws_flush !== 1'b1) begin failed++; $display("FAIL ertn_ws_flush got %0b exp 1", ws_flush); end
    compared++; if (ws_allow_in !== 1'b0) begin failed++; $display("FAIL ertn_allow got %0b exp 0", ws_allow_in); end
    compared++; if (fwd_valid !== 1'b0) begin failed++; $display("FAIL ertn_push_dropped got %0b exp 0", fwd_valid); end
    tick();
    in_v = 0;
    settle();
    compared++; if (ws_allow_in !== 1'b1) begin failed++; $display("FAIL ertn_allow_after got %0b exp 1", ws_allow_in); end
    tick();
    settle();
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL ertn_no_ghost got %0b exp 0", rf_we); end
  endtask

  task automatic test_reset_mid();
    stall = 1; in_v = 1;
    in_e = mk(32'h1c000500, 1'b1, 5'd11, 32'hB1); tick();
    in_e = mk(32'h1c000504, 1'b1, 5'd12, 32'hB2); tick();
    in_v = 0;
    #2; resetn = 0; model_reset(); stall = 0;
    #1;
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL rmid_rf_we got %0b exp 0", rf_we); end
    compared++; if (retire_cnt !== 64'd0) begin failed++; $display("FAIL rmid_retire_cnt got %0h exp 0", retire_cnt); end
    compared++; if (fwd_valid !== 1'b0) begin failed++; $display("FAIL rmid_fwd_valid got %0b exp 0", fwd_valid); end
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
    settle();
    compared++; if (rf_we !== 1'b0) begin failed++; $display("FAIL rmid_after_rf_we got %0b exp 0", rf_we); end
    compared++; if (ws_allow_in !== 1'b1) begin failed++; $display("FAIL rmid_allow got %0b exp 1", ws_allow_in); end
    tick();
  endtask

  task automatic test_random();
    ent_t e;
    for (int n = 0; n < 3000; n++) begin
      e            = '0;
      e.pc         = $urandom;
      e.gr_we      = 1'($urandom_range(0, 1));
      e.dest       = 5'($urandom);
      e.result     = $urandom;
      e.csr_re     = ($urandom_range(0, 3) == 0);
      e.csr_we     = ($urandom_range(0, 3) == 0);
      e.csr_num    = 14'($urandom);
      e.csr_wmask  = $urandom;
      e.csr_wvalue = $urandom;
      e.ertn       = ($urandom_range(0, 15) == 0);
      e.exc        = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      e.vaddr      = $urandom;
      in_e   = e;
      in_v   = ($urandom_range(0, 3) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      rvalue = $urandom;
      settle();
      compared++; if (ws_allow_in !== e_allow) begin failed++; $display("FAIL rnd_allow[%0d] got %0b exp %0b", n, ws_allow_in, e_allow); end
      compared++; if (rf_we !== e_rf_we) begin failed++; $display("FAIL rnd_rf_we[%0d] got %0b exp %0b", n, rf_we, e_rf_we); end
      compared++; if (csr_we !== e_csr_we) begin failed++; $display("FAIL rnd_csr_we[%0d] got %0b exp %0b", n, csr_we, e_csr_we); end
      compared++; if (csr_re !== e_csr_re) begin failed++; $display("FAIL rnd_csr_re[%0d] got %0b exp %0b", n, csr_re, e_csr_re); end
      compared++; if (wb_ex !== e_wb_ex) begin failed++; $display("FAIL rnd_wb_ex[%0d] got %0b exp %0b", n, wb_ex, e_wb_ex); end
      compared++; if (ertn_flush !== e_ertn) begin failed++; $display("FAIL rnd_ertn[%0d] got %0b exp %0b", n, ertn_flush, e_ertn); end
      compared++; if (ws_flush !== flush_pend) begin failed++; $display("FAIL rnd_ws_flush[%0d] got %0b exp %0b", n, ws_flush, flush_pend); end
      compared++; if (retire_cnt !== rcnt) begin failed++; $display("FAIL rnd_retire_cnt[%0d] got %0h exp %0h", n, retire_cnt, rcnt); end
      compared++; if (fwd_valid !== e_fwd_valid) begin failed++; $display("FAIL rnd_fwd_valid[%0d] got %0b exp %0b", n, fwd_valid, e_fwd_valid); end
      compared++; if (fwd_csr_pending !== e_pend) begin failed++; $display("FAIL rnd_pending[%0d] got %0b exp %0b", n, fwd_csr_pending, e_pend); end
      if (e_rf_we) begin
        compared++; if (rf_waddr !== e_waddr) begin failed++; $display("FAIL rnd_waddr[%0d] got %0d exp %0d", n, rf_waddr, e_waddr); end
        compared++; if (rf_wdata !== e_wdata) begin failed++; $display("FAIL rnd_wdata[%0d] got %0h exp %0h", n, rf_wdata, e_wdata); end
      end
      if (e_wb_ex) begin
        compared++; if (wb_ecode !== e_ecode) begin failed++; $display("FAIL rnd_ecode[%0d] got %0h exp %0h", n, wb_ecode, e_ecode); end
        compared++; if (wb_vaddr !== e_vaddr) begin failed++; $display("FAIL rnd_vaddr[%0d] got %0h exp %0h", n, wb_vaddr, e_vaddr); end
        compared++; if (wb_esubcode !== 9'd0) begin failed++; $display("FAIL rnd_esubcode[%0d] got %0h exp 0", n, wb_esubcode); end
      end
      if (e_retire) begin
        compared++; if (wb_pc !== e_pc) begin failed++; $display("FAIL rnd_pc[%0d] got %0h exp %0h", n, wb_pc, e_pc); end
      end
      if (e_fwd_valid) begin
        compared++; if (fwd_dest !== e_fwd_dest) begin failed++; $display("FAIL rnd_fwd_dest[%0d] got %0d exp %0d", n, fwd_dest, e_fwd_dest); end
        compared++; if (fwd_data !== e_fwd_data) begin failed++; $display("FAIL rnd_fwd_data[%0d] got %0h exp %0h", n, fwd_data, e_fwd_data); end
      end
      tick();
    end
    in_v = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_exception();
    test_csr_read();
    test_ertn();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
